mrfm_decim_avg: RTL and testbench
=================================

MRFM_DECIM_AVG -- requirements
Module: mrfm_decim_avg

Interface
REQ-001 Parameter: SR_ADDR, default 7'd72, serial settings-register address holding the decimation shift.
REQ-002 Parameter: CH_W, default 16, channel sample width in bits.
REQ-003 Port: clock  in  1  single clock for all logic (clk64 domain).
REQ-004 Port: reset_n  in  1  asynchronous, active-low reset.
REQ-005 Port: enable  in  1  run enable; low holds the block idle and cleared.
REQ-006 Port: serial_strobe / serial_addr / serial_data  in  1/7/32  settings bus write, qualified by strobe.
REQ-007 Port: in_strobe  in  1  one-cycle qualifier for the input channels.
REQ-008 Port: i_in, q_in, ip_in, qp_in  in  CH_W each  signed samples, consumed from the lock-in processor.
REQ-009 Port: out_strobe  out  1  one-cycle qualifier, driven to the rx buffer rxstrobe.
REQ-010 Port: i_out, q_out, ip_out, qp_out  out  CH_W each  signed averaged samples, driven to rx buffer ch_0..ch_3.
REQ-011 Port: shift_rb  out  4  currently applied shift k, for readback.

Function
REQ-012 The block SHALL latch k = serial_data[3:0] on serial_strobe with serial_addr==SR_ADDR; values above 8 clamp to 8.
REQ-013 Decimation factor SHALL be N = 2^k; one output per N accepted input strobes.
REQ-014 Each channel SHALL accumulate into a signed CH_W+8 bit accumulator; accumulation cannot overflow.
REQ-015 The state machine SHALL have three states: IDLE, ACCUM, DUMP.
REQ-016 IDLE -> ACCUM when enable is high. ACCUM -> IDLE when enable is low, with accumulators and counter cleared.
REQ-017 In ACCUM, each in_strobe SHALL add the inputs and increment an 8-bit sample counter.
REQ-018 The strobe completing N samples SHALL move ACCUM -> DUMP. On that clock, the sums SHALL be captured and the accumulators reloaded with zero.
REQ-019 DUMP SHALL assert out_strobe for exactly one cycle and return to ACCUM.
REQ-020 Latency from the completing in_strobe to out_strobe SHALL be exactly 1 clock.
REQ-021 An in_strobe arriving during DUMP SHALL be accepted as sample 1 of the next block; no sample is lost.
REQ-022 Output value SHALL be the sum arithmetically shifted right by k, truncated to CH_W bits. With k=0, the output is the input delayed 1 clock.
REQ-023 Outputs SHALL hold their value between out_strobe pulses.
REQ-024 A settings write SHALL restart the block on the next clock: counter and accumulators cleared, no out_strobe for the partial block.
REQ-025 If a settings write and an in_strobe coincide, the write SHALL win and the sample SHALL be discarded.
REQ-026 If enable falls during DUMP, the pending out_strobe SHALL still issue, then the block enters IDLE.

Reset
REQ-027 On reset_n low, the block SHALL immediately set: state IDLE, k=0, counter 0, all accumulators 0, all outputs 0, out_strobe 0.
REQ-028 Reset release SHALL be synchronised internally (two-flop deassertion) before state leaves IDLE.

Configuration
REQ-029 With MRFM_DECIM_AVG_ROUND_EN defined, the block SHALL add 2^(k-1) before the shift when k>0 (round half up). The result fits CH_W with no saturation needed.
REQ-030 Without MRFM_DECIM_AVG_ROUND_EN, the block SHALL truncate toward negative infinity, with no rounding adder present.

Structure
REQ-031 SR_ADDR value, the max shift (8) and the accumulator guard width (8) SHALL be defined in the shared mrfm.vh header.
REQ-032 One sub-module, mrfm_avg_acc, SHALL implement a single-channel accumulate/shift/round and be instantiated four times.
REQ-033 The control FSM, counter and settings decode SHALL stay in mrfm_decim_avg.

Verification
REQ-034 k=0, enable=1, i_in=1234 strobed each 4 clocks -> out_strobe 1 clock after each strobe, i_out=1234.
REQ-035 k=2, inputs i_in=10,11,12,13 -> single out_strobe after the 4th strobe; i_out=11 truncated, or 12 with ROUND_EN.
REQ-036 k=8, 256 strobes of qp_in=-32768 -> qp_out=-32768, with no wrap; then 256 strobes of 32767 -> qp_out=32767.
REQ-037 k=3, a settings write after 5 strobes, with a coincident strobe -> no output for that block; next out_strobe after 8 further strobes.
REQ-038 Back-to-back strobes every clock with k=1 -> out_strobe every 2 clocks, no sample dropped across DUMP.
REQ-039 reset_n pulsed low mid-block -> all outputs 0 asynchronously, shift_rb=0, first output after reset reflects only post-reset samples.

Source files
------------

// File: rtl/mrfm_decim_avg_pkg.sv
// Shared constants and types for the MRFM decimating averager.
// Holds the settings-register address, the maximum decimation shift and the
// accumulator guard width used by both the control block and the channel slices.
package mrfm_decim_avg_pkg;

    // Settings-bus address of the decimation shift register
    localparam logic [6:0] MRFM_SR_ADDR   = 7'd72;
    // Largest supported shift; N = 2^8 = 256 samples per output
    localparam logic [3:0] MRFM_MAX_SHIFT = 4'd8;
    // Extra accumulator bits so 256 full-scale samples cannot overflow
    localparam int         MRFM_ACC_GUARD = 8;
    // Number of sample channels (I, Q, I', Q')
    localparam int         MRFM_NUM_CH    = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DUMP  = 2'd2
    } state_t;

    // Requested shifts above the maximum are held at the maximum
    function automatic logic [3:0] clamp_shift(input logic [3:0] k);
        return (k > MRFM_MAX_SHIFT) ? MRFM_MAX_SHIFT : k;
    endfunction

endpackage

// File: rtl/mrfm_decim_avg_acc.sv
// Single-channel accumulate / shift / round slice for mrfm_decim_avg.
// On i_dump the running sum (including the current sample) is shifted right
// by i_shift into the output register and the accumulator restarts from zero.
// Optional feature macro: MRFM_DECIM_AVG_ROUND_EN adds 2^(k-1) before the
// shift (round half up); without it the shift truncates toward -infinity.
module mrfm_avg_acc
    import mrfm_decim_avg_pkg::*;
#(
    parameter int CH_W = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   i_clr,
    input  logic                   i_add,
    input  logic                   i_dump,
    input  logic [3:0]             i_shift,
    input  logic signed [CH_W-1:0] i_din,
    output logic signed [CH_W-1:0] o_dout
);

    localparam int ACC_W = CH_W + MRFM_ACC_GUARD;

    logic signed [ACC_W-1:0] r_acc;
    logic signed [CH_W-1:0]  r_out;
    logic signed [ACC_W-1:0] w_din_x;
    logic signed [ACC_W-1:0] w_sum;
    logic signed [ACC_W-1:0] w_rsum;
    logic signed [ACC_W-1:0] w_shifted;
    logic                    w_unused_hi;

    assign w_din_x = {{MRFM_ACC_GUARD{i_din[CH_W-1]}}, i_din};
    assign w_sum   = r_acc + w_din_x;

`ifdef MRFM_DECIM_AVG_ROUND_EN
    // Half an LSB of the output weight; the guard bits absorb it without overflow
    logic signed [ACC_W-1:0] w_rnd;
    assign w_rnd  = (i_shift == 4'd0) ? '0 : (ACC_W'(1) <<< (i_shift - 4'd1));
    assign w_rsum = w_sum + w_rnd;
`else
    assign w_rsum = w_sum;
`endif

    // Arithmetic shift keeps the sign, so truncation is toward -infinity
    assign w_shifted   = w_rsum >>> i_shift;
    assign w_unused_hi = ^w_shifted[ACC_W-1:CH_W];
    assign o_dout      = r_out;

    // Accumulator and held output; dump captures sum+sample and reloads zero
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_acc <= '0;
            r_out <= '0;
        end else if (i_dump) begin
            r_acc <= '0;
            r_out <= w_shifted[CH_W-1:0];
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_add) begin
            r_acc <= w_sum;
        end
    end

endmodule

// File: rtl/mrfm_decim_avg.sv
// MRFM decimating averager: sums 2^k input strobes per channel and emits one
// averaged sample set with a one-cycle out_strobe. Holds the control FSM,
// sample counter and settings decode; the four channel datapaths are
// mrfm_avg_acc slices. Optional feature macro: MRFM_DECIM_AVG_ROUND_EN.
module mrfm_decim_avg
    import mrfm_decim_avg_pkg::*;
#(
    parameter logic [6:0] SR_ADDR = MRFM_SR_ADDR,
    parameter int         CH_W    = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic                   serial_strobe,
    input  logic [6:0]             serial_addr,
    input  logic [31:0]            serial_data,
    input  logic                   in_strobe,
    input  logic signed [CH_W-1:0] i_in,
    input  logic signed [CH_W-1:0] q_in,
    input  logic signed [CH_W-1:0] ip_in,
    input  logic signed [CH_W-1:0] qp_in,
    output logic                   out_strobe,
    output logic signed [CH_W-1:0] i_out,
    output logic signed [CH_W-1:0] q_out,
    output logic signed [CH_W-1:0] ip_out,
    output logic signed [CH_W-1:0] qp_out,
    output logic [3:0]             shift_rb
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_sync;
    logic [3:0]  r_k;
    logic [7:0]  r_cnt;

    logic        w_run;
    logic        w_wr;
    logic        w_accept;
    logic        w_done;
    logic        w_clr;
    logic        w_add;
    logic [8:0]  w_cnt_nxt;
    logic [8:0]  w_n;
    logic        w_unused_sd;

    logic [MRFM_NUM_CH-1:0][CH_W-1:0] w_din;
    logic [MRFM_NUM_CH-1:0][CH_W-1:0] w_dout;

    assign w_run       = r_sync[1];
    assign w_wr        = serial_strobe && (serial_addr == SR_ADDR);
    assign w_unused_sd = ^serial_data[31:4];

    // A settings write wins over a coincident sample; DUMP accepts the next block's first sample
    assign w_accept  = in_strobe && enable && !w_wr &&
                       ((r_state == ST_ACCUM) || (r_state == ST_DUMP));
    assign w_cnt_nxt = {1'b0, r_cnt} + 9'd1;
    assign w_n       = 9'd1 << r_k;
    assign w_done    = w_accept && (w_cnt_nxt == w_n);
    assign w_add     = w_accept && !w_done;

    // Two-flop synchroniser on reset release; the FSM waits for it before running
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_sync <= 2'b00;
        else          r_sync <= {r_sync[0], 1'b1};
    end

    // FSM state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // FSM next state; DUMP lasts one cycle even if enable drops meanwhile
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (enable && w_run) w_state_nxt = ST_ACCUM;
            ST_ACCUM: begin
                if (!enable)     w_state_nxt = ST_IDLE;
                else if (w_done) w_state_nxt = ST_DUMP;
            end
            ST_DUMP: begin
                if (!enable)     w_state_nxt = ST_IDLE;
                else if (w_done) w_state_nxt = ST_DUMP;
                else             w_state_nxt = ST_ACCUM;
            end
            default:             w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: strobe in DUMP, clear whenever idle, disabled or reconfigured
    always_comb begin
        out_strobe = 1'b0;
        w_clr      = 1'b0;
        case (r_state)
            ST_IDLE:  w_clr = 1'b1;
            ST_ACCUM: w_clr = !enable || w_wr;
            ST_DUMP: begin
                out_strobe = 1'b1;
                w_clr      = !enable || w_wr;
            end
            default:  w_clr = 1'b1;
        endcase
    end

    // Sample counter; wraps to zero at block completion
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)             r_cnt <= '0;
        else if (w_clr || w_done) r_cnt <= '0;
        else if (w_accept)        r_cnt <= w_cnt_nxt[7:0];
    end

    // Decimation shift register, clamped on write
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)  r_k <= '0;
        else if (w_wr) r_k <= clamp_shift(serial_data[3:0]);
    end

    assign shift_rb = r_k;

    assign w_din = {qp_in, ip_in, q_in, i_in};

    for (genvar g = 0; g < MRFM_NUM_CH; g++) begin : g_ch
        mrfm_avg_acc #(
            .CH_W (CH_W)
        ) u_acc (
            .clock   (clock),
            .reset_n (reset_n),
            .i_clr   (w_clr),
            .i_add   (w_add),
            .i_dump  (w_done),
            .i_shift (r_k),
            .i_din   (w_din[g]),
            .o_dout  (w_dout[g])
        );
    end

    assign i_out  = w_dout[0];
    assign q_out  = w_dout[1];
    assign ip_out = w_dout[2];
    assign qp_out = w_dout[3];

endmodule

// File: tb/tb_mrfm_decim_avg.sv
// Self-checking bench for mrfm_decim_avg. A sample-level model keeps per-channel
// running sums and a sample count; when the count reaches 2^k it expects an
// out_strobe on the following cycle carrying floor(sum / 2^k) (or round-half-up
// with MRFM_DECIM_AVG_ROUND_EN). Every cycle checks strobe, held outputs, shift_rb.
module tb_mrfm_decim_avg;

    localparam logic [6:0] SR = 7'd72;

    logic               clock = 1'b0;
    logic               reset_n = 1'b0;
    logic               enable = 1'b1;
    logic               serial_strobe = 1'b0;
    logic [6:0]         serial_addr = '0;
    logic [31:0]        serial_data = '0;
    logic               in_strobe = 1'b0;
    logic signed [15:0] i_in = '0, q_in = '0, ip_in = '0, qp_in = '0;
    logic               out_strobe;
    logic signed [15:0] i_out, q_out, ip_out, qp_out;
    logic [3:0]         shift_rb;

    always #5 clock = ~clock;

    mrfm_decim_avg #(.SR_ADDR(SR), .CH_W(16)) dut (
        .clock (clock), .reset_n (reset_n), .enable (enable),
        .serial_strobe (serial_strobe), .serial_addr (serial_addr), .serial_data (serial_data),
        .in_strobe (in_strobe), .i_in (i_in), .q_in (q_in), .ip_in (ip_in), .qp_in (qp_in),
        .out_strobe (out_strobe), .i_out (i_out), .q_out (q_out), .ip_out (ip_out), .qp_out (qp_out),
        .shift_rb (shift_rb)
    );

    int     n_chk = 0;
    int     n_err = 0;
    int     k_m = 0;
    int     cnt_m = 0;
    longint sum_m [4];
    longint last_m [4];

    task automatic chk(input string tag, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // Average of a block as the spec defines it: floor division, optional half-up rounding
    function automatic longint avg_of(input longint s, input int k);
        longint n;
        longint q;
        n = longint'(1) << k;
`ifdef MRFM_DECIM_AVG_ROUND_EN
        if (k > 0) s = s + n / 2;
`endif
        q = s / n;
        if ((s % n != 0) && (s < 0)) q = q - 1;
        return q;
    endfunction

    function automatic logic signed [15:0] rnd16();
        return 16'($urandom);
    endfunction

    task automatic clr_m();
        cnt_m = 0;
        for (int c = 0; c < 4; c++) sum_m[c] = 0;
    endtask

    // One clock of stimulus: update model, drive, clock, check
    task automatic cyc(input bit stb, input bit wr, input logic [6:0] wa, input logic [31:0] wd,
                       input logic signed [15:0] a, input logic signed [15:0] b,
                       input logic signed [15:0] c, input logic signed [15:0] d);
        bit     exp_stb;
        longint v [4];
        exp_stb = 1'b0;
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        if (wr && wa == SR) begin
            k_m = (wd[3:0] > 4'd8) ? 8 : int'(wd[3:0]);
            clr_m();
        end else if (!enable) begin
            clr_m();
        end else if (stb) begin
            for (int c2 = 0; c2 < 4; c2++) sum_m[c2] += v[c2];
            cnt_m++;
            if (cnt_m == (1 << k_m)) begin
                for (int c2 = 0; c2 < 4; c2++) last_m[c2] = avg_of(sum_m[c2], k_m);
                exp_stb = 1'b1;
                clr_m();
            end
        end
        in_strobe = stb; serial_strobe = wr; serial_addr = wa; serial_data = wd;
        i_in = a; q_in = b; ip_in = c; qp_in = d;
        @(posedge clock);
        #1;
        in_strobe = 1'b0; serial_strobe = 1'b0;
        chk("out_strobe", out_strobe, exp_stb);
        chk("i_out", i_out, last_m[0]);
        chk("q_out", q_out, last_m[1]);
        chk("ip_out", ip_out, last_m[2]);
        chk("qp_out", qp_out, last_m[3]);
        chk("shift_rb", shift_rb, k_m);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, SR, 0, rnd16(), rnd16(), rnd16(), rnd16());
    endtask

    task automatic send(input logic signed [15:0] a, input logic signed [15:0] b,
                        input logic signed [15:0] c, input logic signed [15:0] d);
        cyc(1, 0, SR, 0, a, b, c, d);
    endtask

    task automatic send_rnd();
        send(rnd16(), rnd16(), rnd16(), rnd16());
    endtask

    task automatic set_k(input logic [31:0] k);
        cyc(0, 1, SR, k, rnd16(), rnd16(), rnd16(), rnd16());
    endtask

    task automatic model_reset();
        k_m = 0;
        clr_m();
        for (int c = 0; c < 4; c++) last_m[c] = 0;
    endtask

    initial begin
        model_reset();
        // Reset state while reset is held
        #12;
        chk("rst_strobe", out_strobe, 0);
        chk("rst_i", i_out, 0);
        chk("rst_qp", qp_out, 0);
        chk("rst_shift", shift_rb, 0);
        #11 reset_n = 1'b1;
        @(posedge clock); #1;
        idle(4);

        // k=0: each strobe comes back one clock later unchanged
        for (int i = 0; i < 5; i++) begin
            send(16'sd1234, rnd16(), rnd16(), rnd16());
            chk("k0_i1234", i_out, 1234);
            idle(3);
        end
        // k=0 back-to-back: every strobe produces an output
        for (int i = 0; i < 10; i++) send_rnd();

        // k=2: 10,11,12,13 with random gaps
        set_k(2);
        for (int i = 0; i < 4; i++) begin
            send(16'(10 + i), rnd16(), rnd16(), rnd16());
            idle($urandom_range(0, 2));
        end
`ifdef MRFM_DECIM_AVG_ROUND_EN
        chk("k2_avg", i_out, 12);
`else
        chk("k2_avg", i_out, 11);
`endif

        // k=8 full-scale negative then positive, no wrap
        set_k(8);
        for (int i = 0; i < 256; i++) send(rnd16(), rnd16(), rnd16(), -16'sd32768);
        chk("k8_min", qp_out, -32768);
        for (int i = 0; i < 256; i++) send(rnd16(), rnd16(), rnd16(), 16'sd32767);
        chk("k8_max", qp_out, 32767);

        // k=3: restart after 5 samples with a coincident strobe, then 8 more
        set_k(3);
        for (int i = 0; i < 5; i++) send_rnd();
        cyc(1, 1, SR, 3, rnd16(), rnd16(), rnd16(), rnd16());
        for (int i = 0; i < 8; i++) send_rnd();

        // k=1 back-to-back: output every 2 clocks, nothing lost across DUMP
        set_k(1);
        for (int i = 0; i < 20; i++) send_rnd();

        // Clamp and foreign-address write that must not disturb the block
        set_k(32'hFFFF_FFFD);
        chk("clamp", shift_rb, 8);
        set_k(4);
        send_rnd();
        cyc(1, 1, 7'd73, 32'h1, rnd16(), rnd16(), rnd16(), rnd16());
        for (int i = 0; i < 64; i++) begin
            if ($urandom_range(0, 2) == 0) idle(1);
            send_rnd();
        end

        // Enable drop mid-block discards the partial block
        set_k(2);
        send_rnd(); send_rnd();
        enable = 1'b0;
        cyc(1, 0, SR, 0, rnd16(), rnd16(), rnd16(), rnd16());
        idle(1);
        enable = 1'b1;
        idle(1);
        for (int i = 0; i < 4; i++) send_rnd();

        // Asynchronous reset mid-block
        set_k(3);
        for (int i = 0; i < 3; i++) send_rnd();
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        chk("arst_strobe", out_strobe, 0);
        chk("arst_i", i_out, 0);
        chk("arst_q", q_out, 0);
        chk("arst_ip", ip_out, 0);
        chk("arst_qp", qp_out, 0);
        chk("arst_shift", shift_rb, 0);
        @(posedge clock);
        #3 reset_n = 1'b1;
        @(posedge clock); #1;
        idle(4);
        set_k(2);
        for (int i = 0; i < 4; i++) send_rnd();
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
